// File: rtl/alu_iter_if.sv
// Handshake and operand bundle between the ALU_Ctrl decoder (master) and the
// iterative execute-stage ALU (slave).
interface alu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [3:0]       ctrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             ovf_o;
  logic             illegal_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, ctrl_i, src1_i, src2_i,
    input  result_o, zero_o, ovf_o, illegal_o, busy_o, done_o
  );

  modport slave (
    input  start_i, ctrl_i, src1_i, src2_i,
    output result_o, zero_o, ovf_o, illegal_o, busy_o, done_o
  );
endinterface

// File: rtl/alu_iter.sv
// Execute-stage ALU: AND/OR/ADD/SUB/SLT complete in one cycle, MUL is a
// shift-add loop of WIDTH iterations so no combinational multiplier is needed.
// Results are registered and held until the next completion.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  alu_iter_if.slave  bus
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] op_res;
  logic             op_ovf;
  logic             op_illegal;
  logic             op_is_mul;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] b_neg;
  logic [WIDTH-1:0] diff;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_next;

  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ovf_q;
  logic             illegal_q;

  logic accept;
  logic mul_last;

  assign accept   = bus.start_i && ((state == S_IDLE) || (state == S_DONE));
  assign mul_last = (state == S_MUL) && (cnt == CNT_LAST);

  // Single-cycle operation results, overflow and illegal-code decode
  always_comb begin
    sum        = bus.src1_i + bus.src2_i;
    b_neg      = ~bus.src2_i + 1'b1;
    diff       = bus.src1_i + b_neg;
    op_res     = '0;
    op_ovf     = 1'b0;
    op_illegal = 1'b0;
    op_is_mul  = 1'b0;
    case (bus.ctrl_i)
      OP_AND: op_res = bus.src1_i & bus.src2_i;
      OP_OR:  op_res = bus.src1_i | bus.src2_i;
      OP_ADD: begin
        op_res = sum;
        op_ovf = (bus.src1_i[WIDTH-1] == bus.src2_i[WIDTH-1]) &&
                 (sum[WIDTH-1] != bus.src1_i[WIDTH-1]);
      end
      OP_SUB: begin
        op_res = diff;
        op_ovf = (bus.src1_i[WIDTH-1] == b_neg[WIDTH-1]) &&
                 (diff[WIDTH-1] != bus.src1_i[WIDTH-1]);
      end
      OP_SLT: op_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src1_i) < $signed(bus.src2_i))};
      OP_MUL: op_is_mul = 1'b1;
      default: op_illegal = 1'b1;
    endcase
  end

  // Accumulator value after the current shift-add step
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state decode; a start in DONE is accepted so ops can run back to back
  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) state_next = op_is_mul ? S_MUL : S_DONE;
        else        state_next = S_IDLE;
      end
      S_MUL:   state_next = mul_last ? S_DONE : S_MUL;
      default: state_next = S_IDLE;
    endcase
  end

  // Operand latch, shift-add iteration and result registers; reset drops any partial product
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_q  <= '0;
      zero_q    <= 1'b1;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      if (accept && op_is_mul) begin
        mcand  <= bus.src1_i;
        mplier <= bus.src2_i;
        acc    <= '0;
        cnt    <= '0;
      end else if (accept) begin
        result_q  <= op_res;
        zero_q    <= (op_res == '0);
        ovf_q     <= op_ovf;
        illegal_q <= op_illegal;
      end
      if (state == S_MUL) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (mul_last) begin
          result_q  <= acc_next;
          zero_q    <= (acc_next == '0);
          ovf_q     <= 1'b0;
          illegal_q <= 1'b0;
        end
      end
    end
  end

  // Status outputs come straight from the state; data outputs from their registers
  always_comb begin
    bus.busy_o    = (state == S_MUL);
    bus.done_o    = (state == S_DONE);
    bus.result_o  = result_q;
    bus.zero_o    = zero_q;
    bus.ovf_o     = ovf_q;
    bus.illegal_o = illegal_q;
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter: a table of single-cycle ops plus hand-written
// sequences for MUL timing, start-while-busy, back-to-back and mid-MUL reset.
module tb_alu_iter;

  localparam int WIDTH = 32;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_MUL = 4'b1000;

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        ill;
  } vec_t;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  vec_t vecs[15];

  alu_iter_if #(.WIDTH(WIDTH)) bus ();

  alu_iter #(.WIDTH(WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] exp_res,
                             input logic exp_zero, input logic exp_ovf,
                             input logic exp_ill, input logic exp_busy,
                             input logic exp_done);
    compared++;
    if (bus.result_o !== exp_res || bus.zero_o !== exp_zero || bus.ovf_o !== exp_ovf ||
        bus.illegal_o !== exp_ill || bus.busy_o !== exp_busy || bus.done_o !== exp_done) begin
      mismatched++;
      $display("[TB] FAIL %s: got res=%h z=%b ovf=%b ill=%b busy=%b done=%b, expected res=%h z=%b ovf=%b ill=%b busy=%b done=%b",
               name, bus.result_o, bus.zero_o, bus.ovf_o, bus.illegal_o, bus.busy_o, bus.done_o,
               exp_res, exp_zero, exp_ovf, exp_ill, exp_busy, exp_done);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drives one request at a falling edge; the following rising edge accepts it.
  task automatic applyStimulus(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.ctrl_i  = ctrl;
    bus.src1_i  = a;
    bus.src2_i  = b;
  endtask

  // Starts a MUL, counts busy cycles (bounded), then checks result and the done pulse.
  task automatic runMul(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res);
    int n;
    applyStimulus(C_MUL, a, b);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.src1_i  = 32'hDEAD_BEEF;
    bus.src2_i  = 32'h1234_5678;
    n = 0;
    while (bus.busy_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkValue({name, " busy cycles"}, n, 32);
    checkOutput({name, " done"}, exp_res, (exp_res == 32'h0), 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput({name, " after"}, exp_res, (exp_res == 32'h0), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    compared   = 0;
    mismatched = 0;

    vecs[0]  = '{"add_ovf_pos", C_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{"add_small",   C_ADD, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{"add_wrap",    C_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{"add_ovf_neg", C_ADD, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{"sub_zero",    C_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{"sub_ovf",     C_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{"sub_neg",     C_SUB, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{"and",         C_AND, 32'h0000_00F0, 32'h0000_003C, 32'h0000_0030, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{"or",          C_OR,  32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{"slt_neg",     C_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{"slt_false",   C_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{"slt_min",     C_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{"illegal_f",   4'b1111, 32'h0000_0012, 32'h0000_0034, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{"clear_ill",   C_ADD, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{"illegal_3",   4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.ctrl_i  = 4'b0000;
    bus.src1_i  = '0;
    bus.src2_i  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Table of single-cycle ops: done one cycle after acceptance, then held with done low
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].ctrl, vecs[i].a, vecs[i].b);
      @(negedge clk);
      bus.start_i = 1'b0;
      checkOutput(vecs[i].name, vecs[i].res, vecs[i].zero, vecs[i].ovf, vecs[i].ill, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput({vecs[i].name, " hold"}, vecs[i].res, vecs[i].zero, vecs[i].ovf, vecs[i].ill, 1'b0, 1'b0);
    end

    // Back-to-back: SUB 5-5 then SLT -1<1 with start held high
    applyStimulus(C_SUB, 32'h5, 32'h5);
    @(negedge clk);
    checkOutput("b2b sub", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.ctrl_i = C_SLT;
    bus.src1_i = 32'hFFFF_FFFF;
    bus.src2_i = 32'h1;
    @(negedge clk);
    bus.start_i = 1'b0;
    checkOutput("b2b slt", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("b2b idle", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    runMul("mul 7*6", 32'h7, 32'h6, 32'd42);
    runMul("mul wrap", 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE);
    runMul("mul hi dropped", 32'h0001_0000, 32'h0001_0000, 32'h0);
    runMul("mul 9*9", 32'h9, 32'h9, 32'd81);

    // Start while busy is ignored: no requeue, no extra done, operands not resampled
    applyStimulus(C_MUL, 32'h7, 32'h6);
    @(negedge clk);
    bus.start_i = 1'b0;
    n = 0;
    while (bus.busy_o && n < 100) begin
      n++;
      if (n == 5) begin
        bus.start_i = 1'b1;
        bus.ctrl_i  = C_ADD;
        bus.src1_i  = 32'h1;
        bus.src2_i  = 32'h1;
      end
      if (n == 8) bus.start_i = 1'b0;
      @(negedge clk);
    end
    checkValue("busy start busy cycles", n, 32);
    checkOutput("busy start done", 32'd42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("busy start no extra done", 32'd42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a MUL discards it
    applyStimulus(C_MUL, 32'h7, 32'h6);
    @(negedge clk);
    bus.start_i = 1'b0;
    n = 0;
    while (bus.busy_o && n < 10) begin
      n++;
      @(negedge clk);
    end
    checkValue("pre-reset busy", n, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid-mul reset", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("post reset idle", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(C_AND, 32'hF0, 32'h3C);
    @(negedge clk);
    bus.start_i = 1'b0;
    checkOutput("and after reset", 32'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
